instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/legv8_pkg.sv | 20 ++
 rtl/instruction_fetch_program_counter.sv | 48 ++++
 rtl/instruction_fetch.sv | 127 ++++++++++++
 tb/tb_instruction_fetch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared widths, PC step and fetch state encoding
//
// Purpose: constants shared by the instruction-fetch slice.
//   ADDR_W  : PC / instruction-memory address width
//   INSTR_W : instruction word width
//   PC_INC  : byte distance between consecutive instructions
//   ST_REQ  : fetch FSM, memory request outstanding
//   ST_HOLD : fetch FSM, fetched word buffered while downstream is stalled
package legv8_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  typedef logic [0:0] fetch_state_t;

  localparam fetch_state_t ST_REQ  = 1'b0;
  localparam fetch_state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// rtl/instruction_fetch_program_counter.sv - PC register with increment and redirect mux
//
// Purpose: holds the fetch PC and chooses its next value.
// Ports:
//   clock    : single clock, rising edge
//   reset    : synchronous active-high, loads RESET_PC
//   advance  : step PC by PC_INC (wraps modulo 2^N)
//   redirect : load target with bits [1:0] cleared; wins over advance
//   target   : redirect address
//   pc       : current PC
module program_counter
  import legv8_pkg::*;
#(
  parameter int            N        = ADDR_W,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  input  logic         redirect,
  input  logic [N-1:0] target,
  output logic [N-1:0] pc
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      // Instructions are word aligned; drop the low address bits.
      pc_d = target & ~(N'(3));
    end else if (advance) begin
      pc_d = pc_q + N'(PC_INC);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch FSM with stall buffer
//
// Purpose: requests words from instruction memory at the PC and presents them
// to the instruction register, buffering one word while downstream stalls.
// Ports:
//   clock, reset   : single clock, synchronous active-high reset
//   stall          : instruction register cannot accept this cycle
//   branch_taken   : one-cycle redirect request, highest priority
//   branch_target  : redirect address
//   imem_req       : memory read request (REQ state, not in reset)
//   imem_addr      : memory read address, equal to the PC
//   imem_ready     : imem_data valid for imem_addr this cycle
//   imem_data      : returned instruction word
//   ir_D           : instruction for the instruction register D input
//   ir_load        : one-cycle load strobe per delivered instruction
//   pc_out         : address of the instruction on ir_D
module instruction_fetch
  import legv8_pkg::*;
#(
  parameter int           N        = ADDR_W,
  parameter int           IW       = INSTR_W,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [N-1:0]  branch_target,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] ir_D,
  output logic          ir_load,
  output logic [N-1:0]  pc_out
);

  fetch_state_t  state_q, state_d;
  logic [IW-1:0] buf_data_q, buf_data_d;
  logic [N-1:0]  buf_pc_q, buf_pc_d;
  logic [IW-1:0] ir_d_q, ir_d_d;
  logic [N-1:0]  pc_out_q, pc_out_d;
  logic          ir_load_q, ir_load_d;
  logic          pc_advance;
  logic [N-1:0]  pc;

  program_counter #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .advance  (pc_advance),
    .redirect (branch_taken),
    .target   (branch_target),
    .pc       (pc)
  );

  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    ir_d_d     = ir_d_q;
    pc_out_d   = pc_out_q;
    ir_load_d  = 1'b0;
    pc_advance = 1'b0;

    if (branch_taken) begin
      // Redirect squashes whatever is in flight or buffered.
      state_d    = ST_REQ;
      buf_data_d = '0;
      buf_pc_d   = '0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_ready) begin
            if (!stall) begin
              ir_d_d     = imem_data;
              pc_out_d   = pc;
              ir_load_d  = 1'b1;
              pc_advance = 1'b1;
            end else begin
              buf_data_d = imem_data;
              buf_pc_d   = pc;
              state_d    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ir_d_d     = buf_data_q;
            pc_out_d   = buf_pc_q;
            ir_load_d  = 1'b1;
            pc_advance = 1'b1;
            state_d    = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_REQ;
      buf_data_q <= '0;
      buf_pc_q   <= '0;
      ir_d_q     <= '0;
      pc_out_q   <= '0;
      ir_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
      ir_d_q     <= ir_d_d;
      pc_out_q   <= pc_out_d;
      ir_load_q  <= ir_load_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ) && !reset;
  assign imem_addr = pc;
  assign ir_D      = ir_d_q;
  assign ir_load   = ir_load_q;
  assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  localparam int N  = 64;
  localparam int IW = 32;

  logic          clock;
  logic          reset;
  logic          stall;
  logic          branch_taken;
  logic [N-1:0]  branch_target;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_ready;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] ir_D;
  logic          ir_load;
  logic [N-1:0]  pc_out;

  typedef struct {
    logic [IW-1:0] data;
    logic [N-1:0]  pc;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [IW-1:0] last_ir;
  logic [N-1:0]  last_pc;

  instruction_fetch #(.N(N), .IW(IW), .RESET_PC('0)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .ir_D          (ir_D),
    .ir_load       (ir_load),
    .pc_out        (pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] d, input logic [N-1:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    sb.push_back(e);
  endtask

  // Advance one clock, then check the registered outputs against the
  // scoreboard (delivery) or against the last delivered values (hold).
  task automatic step(input logic exp_load);
    exp_t e;
    @(posedge clock);
    #1;
    check("ir_load", 64'(ir_load), 64'(exp_load));
    if (exp_load) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("ir_D", 64'(ir_D), 64'(e.data));
        check("pc_out", pc_out, e.pc);
        last_ir = e.data;
        last_pc = e.pc;
      end
    end else begin
      check("ir_D_hold", 64'(ir_D), 64'(last_ir));
      check("pc_out_hold", pc_out, last_pc);
    end
  endtask

  task automatic redirect(input logic [N-1:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    imem_ready    = 1'b0;
    stall         = 1'b0;
    step(1'b0);
    branch_taken  = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_data = '0;
    last_ir = '0; last_pc = '0;

    // Reset state
    step(1'b0);
    check("rst_req", 64'(imem_req), 64'(0));
    reset = 1'b0;
    #1;
    check("first_req", 64'(imem_req), 64'(1));
    check("first_addr", imem_addr, 64'h0);

    // Zero-wait streaming: one instruction per cycle
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stream_addr", imem_addr, 64'(4 * i));
      imem_data = 32'h9100_0000 + 32'(i);
      push(imem_data, 64'(4 * i));
      step(1'b1);
    end
    check("stream_end_addr", imem_addr, 64'd16);

    // Stall with ready at PC=8: word buffered, then released
    redirect(64'd8);
    check("at8_addr", imem_addr, 64'd8);
    imem_ready = 1'b1; stall = 1'b1; imem_data = 32'hD280_0020;
    step(1'b0);
    check("hold_req", 64'(imem_req), 64'(0));
    imem_data = 32'h0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0);
      check("hold_req_k", 64'(imem_req), 64'(0));
      check("hold_addr", imem_addr, 64'd8);
    end
    stall = 1'b0; imem_ready = 1'b0;
    push(32'hD280_0020, 64'd8);
    step(1'b1);
    check("after_hold_addr", imem_addr, 64'd12);
    check("after_hold_req", 64'(imem_req), 64'(1));

    // Branch coincident with a ready word: word dropped, target aligned
    imem_ready = 1'b1; imem_data = 32'hDEAD_BEEF;
    branch_taken = 1'b1; branch_target = 64'h103;
    step(1'b0);
    branch_taken = 1'b0;
    #1;
    check("br_addr", imem_addr, 64'h100);

    // Branch while holding a buffered word: buffer discarded
    imem_ready = 1'b1; stall = 1'b1; imem_data = 32'h1111_2222;
    step(1'b0);
    branch_taken = 1'b1; branch_target = 64'h200;
    step(1'b0);
    branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    #1;
    check("br_hold_addr", imem_addr, 64'h200);
    check("br_hold_req", 64'(imem_req), 64'(1));
    step(1'b0);

    // Memory wait states at PC=20
    redirect(64'd20);
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      check("wait_req", 64'(imem_req), 64'(1));
      check("wait_addr", imem_addr, 64'd20);
    end
    imem_ready = 1'b1; imem_data = 32'hAAAA_5555;
    push(32'hAAAA_5555, 64'd20);
    step(1'b1);
    check("wait_next_addr", imem_addr, 64'd24);

    // PC wrap at the top of the address space
    redirect(64'hFFFF_FFFF_FFFF_FFFF);
    check("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_ready = 1'b1; imem_data = 32'h0BAD_F00D;
    push(32'h0BAD_F00D, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1);
    check("wrap_addr", imem_addr, 64'h0);

    // Reset during HOLD: buffered word never delivered
    redirect(64'h40);
    imem_ready = 1'b1; stall = 1'b1; imem_data = 32'h1234_5678;
    step(1'b0);
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b1; branch_target = 64'h80;
    last_ir = '0; last_pc = '0;
    step(1'b0);
    check("rst_hold_req", 64'(imem_req), 64'(0));
    reset = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    #1;
    check("rst_rel_addr", imem_addr, 64'h0);
    check("rst_rel_req", 64'(imem_req), 64'(1));
    step(1'b0);
    imem_ready = 1'b1; imem_data = 32'hCAFE_0001;
    push(32'hCAFE_0001, 64'h0);
    step(1'b1);
    check("post_rst_addr", imem_addr, 64'd4);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
